// File: rtl/w0rm_mem_pkg.sv
// Shared encodings for the W0RM sub-word memory bridge: access sizes, FSM
// states and fault causes.
package w0rm_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT_LD,
    ST_RMW_RD,
    ST_WAIT_RMW,
    ST_WR,
    ST_WAIT_ST,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE,
    FAULT_MISALIGN,
    FAULT_ILLEGAL,
    FAULT_TIMEOUT
  } fault_t;

  // Faults that are visible from the request alone, before any memory access.
  function automatic fault_t accept_fault(input logic rd, input logic wr,
                                          input logic [1:0] size,
                                          input logic [1:0] offset);
    fault_t cause;
    cause = FAULT_NONE;
    if (size == SIZE_ILL || rd == wr)
      cause = FAULT_ILLEGAL;
    else if ((size == SIZE_HALF && offset[0]) || (size == SIZE_WORD && offset != 2'b00))
      cause = FAULT_MISALIGN;
    return cause;
  endfunction

endpackage

// File: rtl/w0rm_mem_lane_merge.sv
// Little-endian lane logic: merges store data into a fetched word and extracts
// a sign/zero-extended sub-word from it.
module w0rm_mem_lane_merge
  import w0rm_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [DATA_WIDTH-1:0] lane_data,
  input  logic [1:0]            size,
  input  logic [1:0]            offset,
  input  logic                  sign,
  output logic [DATA_WIDTH-1:0] merged,
  output logic [DATA_WIDTH-1:0] extracted
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] replicated;
  logic [DATA_WIDTH-1:0] shifted;
  logic [LANES-1:0]      byte_en;

  // Store data is replicated across all lanes so the enable mask alone picks the target.
  always_comb begin
    replicated = lane_data;
    byte_en    = '1;
    case (size)
      SIZE_BYTE: begin
        replicated = {LANES{lane_data[7:0]}};
        byte_en    = LANES'(1) << offset;
      end
      SIZE_HALF: begin
        replicated = {(LANES / 2){lane_data[15:0]}};
        byte_en    = LANES'(3) << {offset[1], 1'b0};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign merged[8*gi +: 8] = byte_en[gi] ? replicated[8*gi +: 8] : word[8*gi +: 8];
  end

  assign shifted = word >> {offset, 3'b000};

  always_comb begin
    case (size)
      SIZE_BYTE: extracted = {{(DATA_WIDTH-8){sign & shifted[7]}}, shifted[7:0]};
      SIZE_HALF: extracted = {{(DATA_WIDTH-16){sign & shifted[15]}}, shifted[15:0]};
      default:   extracted = word;
    endcase
  end

endmodule

// File: rtl/w0rm_mem_subword_bridge.sv
// CPU load/store to word-wide memory bridge: alignment faults, lane extraction,
// read-modify-write for sub-word stores and a no-response timeout.
module w0rm_mem_subword_bridge
  import w0rm_mem_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  cpu_valid_i,
  input  logic                  cpu_read_i,
  input  logic                  cpu_write_i,
  input  logic [1:0]            cpu_size_i,
  input  logic                  cpu_sign_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_data_i,
  input  logic [USER_WIDTH-1:0] cpu_user_i,
  output logic                  cpu_ready_o,
  output logic                  cpu_valid_o,
  output logic [DATA_WIDTH-1:0] cpu_data_o,
  output logic                  cpu_fault_o,
  output logic [USER_WIDTH-1:0] cpu_user_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [USER_WIDTH-1:0] mem_user_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                state_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [1:0]            size_reg;
  logic [1:0]            offset_reg;
  logic                  sign_reg;
  logic [DATA_WIDTH-1:0] store_reg;

  logic                  accept;
  fault_t                accept_cause;
  logic                  timed_out;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] extracted;

  assign cpu_ready_o  = (state_reg == ST_IDLE) && !cpu_reset;
  assign accept       = cpu_ready_o && cpu_valid_i;
  assign accept_cause = accept_fault(cpu_read_i, cpu_write_i, cpu_size_i, cpu_addr_i[1:0]);

  // The counter holds the number of silent wait cycles already seen; this is
  // the last permitted one, so a silent cycle here ends the wait with a fault.
  assign timed_out = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  w0rm_mem_lane_merge #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_merge (
    .word      (mem_data_i),
    .lane_data (store_reg),
    .size      (size_reg),
    .offset    (offset_reg),
    .sign      (sign_reg),
    .merged    (merged),
    .extracted (extracted)
  );

  always_ff @(posedge mem_clk) begin
    if (cpu_reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      size_reg    <= SIZE_BYTE;
      offset_reg  <= 2'b00;
      sign_reg    <= 1'b0;
      store_reg   <= '0;
      cpu_valid_o <= 1'b0;
      cpu_data_o  <= '0;
      cpu_fault_o <= 1'b0;
      cpu_user_o  <= '0;
      mem_valid_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_user_o  <= '0;
    end else begin
      cpu_valid_o <= 1'b0;
      mem_valid_o <= 1'b0;
      mem_read_o  <= 1'b0;
      mem_write_o <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            size_reg    <= cpu_size_i;
            offset_reg  <= cpu_addr_i[1:0];
            sign_reg    <= cpu_sign_i;
            store_reg   <= cpu_data_i;
            cpu_user_o  <= cpu_user_i;
            mem_user_o  <= cpu_user_i;
            mem_addr_o  <= {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
            cpu_data_o  <= '0;
            cpu_fault_o <= 1'b0;
            if (accept_cause != FAULT_NONE) begin
              cpu_fault_o <= 1'b1;
              cpu_valid_o <= 1'b1;
              state_reg   <= ST_RESP;
            end else if (cpu_read_i) begin
              mem_valid_o <= 1'b1;
              mem_read_o  <= 1'b1;
              state_reg   <= ST_RD;
            end else if (cpu_size_i == SIZE_WORD) begin
              mem_valid_o <= 1'b1;
              mem_write_o <= 1'b1;
              mem_data_o  <= cpu_data_i;
              state_reg   <= ST_WR;
            end else begin
              mem_valid_o <= 1'b1;
              mem_read_o  <= 1'b1;
              state_reg   <= ST_RMW_RD;
            end
          end
        end

        ST_RD: begin
          count_reg <= '0;
          state_reg <= ST_WAIT_LD;
        end

        ST_RMW_RD: begin
          count_reg <= '0;
          state_reg <= ST_WAIT_RMW;
        end

        ST_WR: begin
          count_reg <= '0;
          state_reg <= ST_WAIT_ST;
        end

        ST_WAIT_LD: begin
          if (mem_valid_i) begin
            cpu_data_o  <= extracted;
            cpu_valid_o <= 1'b1;
            state_reg   <= ST_RESP;
          end else if (timed_out) begin
            cpu_data_o  <= '0;
            cpu_fault_o <= 1'b1;
            cpu_valid_o <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        // A timeout here abandons the merge, so the write is never issued.
        ST_WAIT_RMW: begin
          if (mem_valid_i) begin
            mem_data_o  <= merged;
            mem_valid_o <= 1'b1;
            mem_write_o <= 1'b1;
            state_reg   <= ST_WR;
          end else if (timed_out) begin
            cpu_fault_o <= 1'b1;
            cpu_valid_o <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        ST_WAIT_ST: begin
          if (mem_valid_i) begin
            cpu_valid_o <= 1'b1;
            state_reg   <= ST_RESP;
          end else if (timed_out) begin
            cpu_fault_o <= 1'b1;
            cpu_valid_o <= 1'b1;
            state_reg   <= ST_RESP;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end

        ST_RESP: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w0rm_mem_subword_bridge.sv
// Bench for the sub-word bridge: vector table plus hand sequences for timeout,
// stray responses and reset in the middle of a read-modify-write.
module tb_w0rm_mem_subword_bridge;

  localparam int TMO = 16;

  logic        mem_clk;
  logic        cpu_reset;
  logic        cpu_valid_i, cpu_read_i, cpu_write_i, cpu_sign_i;
  logic [1:0]  cpu_size_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_user_i;
  logic        cpu_ready_o, cpu_valid_o, cpu_fault_o;
  logic [31:0] cpu_data_o, cpu_user_o;
  logic        mem_valid_o, mem_read_o, mem_write_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_user_o;
  logic        mem_valid_i;
  logic [31:0] mem_data_i;

  w0rm_mem_subword_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .mem_clk(mem_clk), .cpu_reset(cpu_reset),
    .cpu_valid_i(cpu_valid_i), .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i),
    .cpu_size_i(cpu_size_i), .cpu_sign_i(cpu_sign_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_user_i(cpu_user_i), .cpu_ready_o(cpu_ready_o),
    .cpu_valid_o(cpu_valid_o), .cpu_data_o(cpu_data_o), .cpu_fault_o(cpu_fault_o),
    .cpu_user_o(cpu_user_o), .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_user_o(mem_user_o), .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );

  typedef struct {
    bit rd; bit wr; logic [1:0] size; bit sign;
    logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] exp_data; bit exp_fault; int lat; int nreq; logic [31:0] exp_mem;
  } vec_t;

  typedef struct {
    logic [31:0] data; bit fault; logic [31:0] user; int cycle;
  } resp_t;

  typedef struct {
    bit rd; bit wr; logic [31:0] addr; logic [31:0] data; logic [31:0] user;
  } mreq_t;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int resp_seen = 0;
  resp_t sb[$];
  mreq_t mem_reqs[$];
  logic [31:0] mem_model [logic [31:0]];
  int mem_lat = 0;
  bit inject_stray = 1'b0;
  bit pend = 1'b0;
  int pend_cnt = 0;
  bit pend_wr = 1'b0;
  logic [31:0] pend_addr, pend_data;
  vec_t vecs[20];

  initial begin
    mem_clk = 1'b0;
    forever #5 mem_clk = ~mem_clk;
  end

  always @(posedge mem_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  // Memory model: answers each request after mem_lat extra cycles (never if negative).
  always @(posedge mem_clk) begin
    bit fire;
    fire = 1'b0;
    if (mem_valid_o) begin
      mem_reqs.push_back('{rd: mem_read_o, wr: mem_write_o, addr: mem_addr_o,
                           data: mem_data_o, user: mem_user_o});
      if (mem_lat >= 0) begin
        pend = 1'b1; pend_cnt = mem_lat; pend_wr = mem_write_o;
        pend_addr = mem_addr_o; pend_data = mem_data_o;
      end
    end
    if (pend) begin
      if (pend_cnt == 0) begin fire = 1'b1; pend = 1'b0; end
      else pend_cnt--;
    end
    if (fire && pend_wr) mem_model[pend_addr] = pend_data;
    mem_valid_i <= fire || inject_stray;
    mem_data_i  <= (fire && !pend_wr) ? model_word(pend_addr) : 32'h0;
  end

  // Response monitor: pops the scoreboard on every cpu_valid_o pulse.
  always @(negedge mem_clk) begin
    resp_t r;
    if (cpu_valid_o === 1'b1) begin
      resp_seen++;
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL spurious_resp: cpu_valid_o=1 data=0x%08h with no request outstanding (required no pulse)", cpu_data_o);
      end else begin
        r = sb.pop_front();
        check("resp_data", cpu_data_o, r.data);
        check("resp_fault", 32'(cpu_fault_o), 32'(r.fault));
        check("resp_user", cpu_user_o, r.user);
        check("resp_cycle", 32'(cyc), 32'(r.cycle));
      end
    end
  end

  task automatic run_vec(input vec_t v, input logic [31:0] user);
    int base, n;
    resp_t r;
    base = mem_reqs.size();
    @(negedge mem_clk);
    cpu_valid_i = 1'b1; cpu_read_i = v.rd; cpu_write_i = v.wr; cpu_size_i = v.size;
    cpu_sign_i = v.sign; cpu_addr_i = v.addr; cpu_data_i = v.wdata; cpu_user_i = user;
    n = 0;
    while (cpu_ready_o !== 1'b1 && n < 20) begin @(negedge mem_clk); n++; end
    check("ready", 32'(cpu_ready_o), 32'd1);
    r.data = v.exp_data; r.fault = v.exp_fault; r.user = user; r.cycle = cyc + v.lat;
    sb.push_back(r);
    @(negedge mem_clk);
    cpu_valid_i = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge mem_clk); n++; end
    check("resp_arrived", 32'(sb.size()), 32'd0);
    sb.delete();
    check("mem_req_count", 32'(mem_reqs.size() - base), 32'(v.nreq));
    if (v.nreq > 0 && mem_reqs.size() > base) begin
      check("mem_addr", mem_reqs[base].addr, v.addr & ~32'h3);
      check("mem_user", mem_reqs[base].user, user);
    end
    if (v.nreq == 2 && mem_reqs.size() >= base + 2)
      check("rmw_order", 32'({mem_reqs[base].rd, mem_reqs[base+1].wr}), 32'b11);
    if (v.wr && !v.rd && !v.exp_fault)
      check("mem_word", model_word(v.addr & ~32'h3), v.exp_mem);
    $display("txn rd=%0d wr=%0d size=%0d sign=%0d addr=%08h wdata=%08h exp=%08h fault=%0d lat=%0d",
             v.rd, v.wr, v.size, v.sign, v.addr, v.wdata, v.exp_data, v.exp_fault, v.lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (required finish before 200000)");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, seen, n;
    vec_t v;
    //         rd wr size  sg addr           wdata          exp_data       flt lat nreq exp_mem
    vecs[0]  = '{0, 1, 2'b10, 0, 32'h4000_0008, 32'hDEAD_BEEF, 32'h0,         0, 3, 1, 32'hDEAD_BEEF};
    vecs[1]  = '{1, 0, 2'b10, 0, 32'h4000_0008, 32'h0,         32'hDEAD_BEEF, 0, 3, 1, 32'h0};
    vecs[2]  = '{0, 1, 2'b10, 0, 32'h4000_0008, 32'h1122_3344, 32'h0,         0, 3, 1, 32'h1122_3344};
    vecs[3]  = '{0, 1, 2'b00, 0, 32'h4000_000A, 32'h0000_005A, 32'h0,         0, 5, 2, 32'h115A_3344};
    vecs[4]  = '{1, 0, 2'b10, 0, 32'h4000_0008, 32'h0,         32'h115A_3344, 0, 3, 1, 32'h0};
    vecs[5]  = '{0, 1, 2'b10, 0, 32'h4000_0008, 32'h8001_0000, 32'h0,         0, 3, 1, 32'h8001_0000};
    vecs[6]  = '{1, 0, 2'b01, 1, 32'h4000_000A, 32'h0,         32'hFFFF_8001, 0, 3, 1, 32'h0};
    vecs[7]  = '{1, 0, 2'b01, 0, 32'h4000_000A, 32'h0,         32'h0000_8001, 0, 3, 1, 32'h0};
    vecs[8]  = '{1, 0, 2'b00, 1, 32'h4000_000B, 32'h0,         32'hFFFF_FF80, 0, 3, 1, 32'h0};
    vecs[9]  = '{1, 0, 2'b00, 1, 32'h4000_000A, 32'h0,         32'h0000_0001, 0, 3, 1, 32'h0};
    vecs[10] = '{0, 1, 2'b01, 0, 32'h4000_0008, 32'h1234_ABCD, 32'h0,         0, 5, 2, 32'h8001_ABCD};
    vecs[11] = '{1, 0, 2'b10, 0, 32'h4000_0008, 32'h0,         32'h8001_ABCD, 0, 3, 1, 32'h0};
    vecs[12] = '{1, 0, 2'b01, 0, 32'h4000_0001, 32'h0,         32'h0,         1, 1, 0, 32'h0};
    vecs[13] = '{0, 1, 2'b10, 0, 32'h4000_0002, 32'h5555_5555, 32'h0,         1, 1, 0, 32'h0};
    vecs[14] = '{1, 0, 2'b11, 0, 32'h4000_0000, 32'h0,         32'h0,         1, 1, 0, 32'h0};
    vecs[15] = '{1, 1, 2'b10, 0, 32'h4000_0000, 32'h0,         32'h0,         1, 1, 0, 32'h0};
    vecs[16] = '{0, 0, 2'b10, 0, 32'h4000_0000, 32'h0,         32'h0,         1, 1, 0, 32'h0};
    vecs[17] = '{0, 1, 2'b00, 0, 32'h4000_0011, 32'hFFFF_FFEE, 32'h0,         0, 5, 2, 32'h0000_EE00};
    vecs[18] = '{1, 0, 2'b00, 0, 32'h4000_0011, 32'h0,         32'h0000_00EE, 0, 3, 1, 32'h0};
    vecs[19] = '{0, 1, 2'b01, 0, 32'h4000_0012, 32'h0000_BEEF, 32'h0,         0, 5, 2, 32'hBEEF_EE00};

    mem_model[32'h4000_0020] = 32'h0102_0304;
    cpu_reset = 1'b1; cpu_valid_i = 1'b0; cpu_read_i = 1'b0; cpu_write_i = 1'b0;
    cpu_size_i = 2'b00; cpu_sign_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0; cpu_user_i = '0;

    repeat (3) @(negedge mem_clk);
    check("reset_outputs", 32'({mem_valid_o, mem_read_o, mem_write_o, cpu_valid_o, cpu_fault_o,
                                |cpu_data_o, |cpu_user_o, |mem_addr_o, |mem_data_o, |mem_user_o}), 32'h0);
    check("reset_ready", 32'(cpu_ready_o), 32'd0);
    cpu_reset = 1'b0;
    @(negedge mem_clk);
    check("ready_after_reset", 32'(cpu_ready_o), 32'd1);

    for (int i = 0; i < 20; i++) run_vec(vecs[i], 32'hC0DE_0000 + 32'(i));

    // Response on the last permitted wait cycle beats the timeout.
    mem_lat = TMO - 1;
    v = '{1, 0, 2'b10, 0, 32'h4000_0008, 32'h0, 32'h8001_ABCD, 0, TMO + 2, 1, 32'h0};
    run_vec(v, 32'hB0B0_0001);
    // One cycle later is too late: timeout fault, the late response lands in RESP.
    mem_lat = TMO;
    v = '{1, 0, 2'b10, 0, 32'h4000_0008, 32'h0, 32'h0, 1, TMO + 2, 1, 32'h0};
    run_vec(v, 32'hB0B0_0002);
    // Memory never answers.
    mem_lat = -1;
    v = '{1, 0, 2'b10, 0, 32'h5000_0000, 32'h0, 32'h0, 1, TMO + 2, 1, 32'h0};
    run_vec(v, 32'hB0B0_0003);

    // Stray response while idle.
    mem_lat = 0;
    base = mem_reqs.size(); seen = resp_seen;
    @(negedge mem_clk); inject_stray = 1'b1;
    @(negedge mem_clk); inject_stray = 1'b0;
    repeat (3) @(negedge mem_clk);
    check("stray_no_resp", 32'(resp_seen - seen), 32'd0);
    check("stray_no_req", 32'(mem_reqs.size() - base), 32'd0);
    v = '{1, 0, 2'b10, 0, 32'h4000_0008, 32'h0, 32'h8001_ABCD, 0, 3, 1, 32'h0};
    run_vec(v, 32'hB0B0_0004);

    // Reset while waiting for the RMW read; its response arrives after release.
    mem_lat = 4;
    base = mem_reqs.size(); seen = resp_seen;
    @(negedge mem_clk);
    cpu_valid_i = 1'b1; cpu_read_i = 1'b0; cpu_write_i = 1'b1; cpu_size_i = 2'b00;
    cpu_sign_i = 1'b0; cpu_addr_i = 32'h4000_0021; cpu_data_i = 32'h77; cpu_user_i = 32'hFEED;
    n = 0;
    while (cpu_ready_o !== 1'b1 && n < 20) begin @(negedge mem_clk); n++; end
    @(negedge mem_clk); cpu_valid_i = 1'b0;
    @(negedge mem_clk); cpu_reset = 1'b1;
    @(negedge mem_clk);
    check("rst_mid_outputs", 32'({mem_valid_o, mem_read_o, mem_write_o, cpu_valid_o, cpu_fault_o,
                                  |cpu_data_o, |cpu_user_o, |mem_addr_o, |mem_data_o, |mem_user_o}), 32'h0);
    check("rst_mid_ready", 32'(cpu_ready_o), 32'd0);
    @(negedge mem_clk); cpu_reset = 1'b0;
    @(negedge mem_clk);
    check("rst_mid_ready_after", 32'(cpu_ready_o), 32'd1);
    repeat (6) @(negedge mem_clk);
    check("rst_mid_no_resp", 32'(resp_seen - seen), 32'd0);
    check("rst_mid_only_read", 32'(mem_reqs.size() - base), 32'd1);
    check("rst_mid_mem_word", model_word(32'h4000_0020), 32'h0102_0304);
    $display("txn reset during RMW byte store addr=40000021 aborted");
    mem_lat = 0;
    v = '{1, 0, 2'b10, 0, 32'h4000_0020, 32'h0, 32'h0102_0304, 0, 3, 1, 32'h0};
    run_vec(v, 32'hB0B0_0005);

    repeat (2) @(negedge mem_clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
